// File: rtl/video_timing_gen.sv
// Raster timing generator: qualifies PLL lock, then emits hsync/vsync/de/x/y for the panel.
// Optional lock-settle filter is enabled by defining VTG_LOCK_FILTER_EN.
module video_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 48,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 32,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        running
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  if (LOCK_WAIT < 1 || LOCK_WAIT > 65535) begin : g_bad_lock_wait
    $error("video_timing_gen: LOCK_WAIT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        lock_meta_q, locked_s_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        running_q, running_d;
  logic        in_run;

`ifdef VTG_LOCK_FILTER_EN
  localparam logic [15:0] SETTLE_LAST = 16'(LOCK_WAIT - 1);
  logic [15:0] settle_cnt_q, settle_cnt_d;
`endif

  // Next-state and raster counters
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
`ifdef VTG_LOCK_FILTER_EN
    settle_cnt_d = settle_cnt_q;
`endif
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s_q) begin
`ifdef VTG_LOCK_FILTER_EN
          state_d      = SETTLE;
          settle_cnt_d = '0;
`else
          state_d = RUN;
          hcnt_d  = '0;
          vcnt_d  = '0;
`endif
        end
      end
`ifdef VTG_LOCK_FILTER_EN
      SETTLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
`endif
      RUN: begin
        if (!locked_s_q) begin
          // Abandon the current line; relock restarts from (0,0).
          state_d = WAIT_LOCK;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end else begin
          hcnt_d = hcnt_q + 11'd1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output decode; everything is registered so all outputs share one cycle of latency
  always_comb begin
    in_run        = (state_q == RUN);
    de_d          = in_run && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hsync_d       = !(in_run && (hcnt_q >= H_SS) && (hcnt_q < H_SE));
    vsync_d       = !(in_run && (vcnt_q >= V_SS) && (vcnt_q < V_SE));
    x_d           = de_d ? hcnt_q : 11'd0;
    y_d           = de_d ? vcnt_q : 10'd0;
    frame_start_d = in_run && (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
    running_d     = in_run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q   <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= WAIT_LOCK;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
`ifdef VTG_LOCK_FILTER_EN
      settle_cnt_q  <= '0;
`endif
    end else begin
      lock_meta_q   <= locked;
      locked_s_q    <= lock_meta_q;
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
`ifdef VTG_LOCK_FILTER_EN
      settle_cnt_q  <= settle_cnt_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken 16x8 raster (8x4 visible) so whole frames fit.
module tb_video_timing_gen;
  localparam int LW = 20;
`ifdef VTG_LOCK_FILTER_EN
  localparam int START_LAT = LW + 3;
`else
  localparam int START_LAT = 3;
`endif
  // {hsync, vsync, de, x, y, frame_start, running}
  localparam logic [25:0] IDLE = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst, locked;
  logic        hsync, vsync, de, frame_start, running;
  logic [10:0] x;
  logic [9:0]  y;
  int          n_chk = 0;
  int          n_fail = 0;
  int          de_cnt, hs_cnt, vs_cnt;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] obs();
    return {hsync, vsync, de, x, y, frame_start, running};
  endfunction

  // Expected outputs for pixel (h,v) while running: visible h<8,v<4; hsync low h=10..12; vsync low v=5..6
  function automatic logic [25:0] act(input int h, input int v);
    logic d;
    d = (h < 8) && (v < 4);
    return {!(h >= 10 && h < 13), !(v >= 5 && v < 7), d,
            d ? 11'(h) : 11'd0, d ? 10'(v) : 10'd0, (h == 0 && v == 0), 1'b1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [25:0] o, input logic [25:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0;
    tick(2);
    chk("reset", obs(), IDLE);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      chk("no_lock", obs(), IDLE);
    end

    // Startup: first frame_start lands START_LAT+1 edges after locked rises
    locked = 1'b1;
    tick(START_LAT);
    chk("pre_start", obs(), IDLE);
    tick(1);

    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int p = 0; p < 128; p++) begin
      chk("frame", obs(), act(p % 16, p / 16));
      de_cnt += int'(de);
      hs_cnt += int'(!hsync);
      vs_cnt += int'(!vsync);
      tick(1);
    end
    chk("frame2_start", obs(), act(0, 0));
    chk_int("de_count", de_cnt, 32);
    chk_int("hsync_low_count", hs_cnt, 24);
    chk_int("vsync_low_count", vs_cnt, 32);

    // Lock loss at pixel (2,1): three more active pixels, then blank
    tick(18);
    chk("pre_loss", obs(), {1'b1, 1'b1, 1'b1, 11'd2, 10'd1, 1'b0, 1'b1});
    locked = 1'b0;
    tick(3);
    chk("loss_f2", obs(), {1'b1, 1'b1, 1'b1, 11'd5, 10'd1, 1'b0, 1'b1});
    tick(1);
    chk("loss_f3", obs(), IDLE);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("loss_hold", obs(), IDLE);
    end
    locked = 1'b1;
    tick(START_LAT);
    chk("relock_pre", obs(), IDLE);
    tick(1);
    chk("relock_start", obs(), act(0, 0));

    // Go idle, relock, then a 5-cycle drop shortly after: the wait restarts from the final rise
    locked = 1'b0;
    tick(8);
    chk("drop_idle", obs(), IDLE);
    locked = 1'b1;
    tick(12);
    locked = 1'b0;
    tick(5);
    chk("glitch_idle", obs(), IDLE);
    locked = 1'b1;
    tick(START_LAT);
    chk("glitch_pre", obs(), IDLE);
    tick(1);
    chk("glitch_start", obs(), act(0, 0));
    tick(1);
    chk("glitch_px1", obs(), act(1, 0));

    // Reset mid-frame at (3,2) with locked held high
    tick(34);
    chk("pre_rst", obs(), {1'b1, 1'b1, 1'b1, 11'd3, 10'd2, 1'b0, 1'b1});
    rst = 1'b1;
    tick(1);
    chk("rst_hold", obs(), IDLE);
    rst = 1'b0;
    tick(START_LAT);
    chk("rst_pre", obs(), IDLE);
    tick(1);
    chk("rst_restart", obs(), act(0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the graphics path, clocked by the 33.75 MHz pixel clock from the graphics PLL. It qualifies the PLL `locked` flag, holds the display blanked until the clock is stable, then produces `hsync`, `vsync`, data-enable and pixel coordinates for an 800x480 panel at about 65.5 Hz. Downstream pixel fetch and the LCD interface consume its outputs directly.

## Interface
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 40: horizontal front porch, in pixels
- `H_SYNC`, 48: hsync width, in pixels
- `H_BP`, 88: horizontal back porch; H_TOTAL = 976
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 13: vertical front porch, in lines
- `V_SYNC`, 3: vsync width, in lines
- `V_BP`, 32: vertical back porch; V_TOTAL = 528
- `LOCK_WAIT`, 1024: cycles `locked` must stay high before the raster starts (range 1..65535)

Ports:
- `clk` in 1: pixel clock (PLL output 0)
- `rst` in 1: synchronous, active-high reset
- `locked` in 1: PLL lock flag, asynchronous to `clk`
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `de` out 1: data enable, high on visible pixels
- `x` out 11: pixel column; valid when `de`=1
- `y` out 10: pixel row; valid when `de`=1
- `frame_start` out 1: one-cycle pulse on pixel (0,0)
- `running` out 1: high while the state is RUN

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Registers reset to 0.
- States:
  - WAIT_LOCK (reset state): when `locked_s`=1, go to SETTLE and clear `settle_cnt` (16 bit).
  - SETTLE: if `locked_s`=0, go to WAIT_LOCK. If `settle_cnt`=LOCK_WAIT-1, go to RUN and clear `hcnt`/`vcnt`. Otherwise increment `settle_cnt`.
  - RUN: if `locked_s`=0, go to WAIT_LOCK and clear the counters. Otherwise advance the raster.
- Raster counters:
  - `hcnt` runs 0..H_TOTAL-1 and wraps to 0.
  - `vcnt` increments only when `hcnt` wraps. It runs 0..V_TOTAL-1 and wraps to 0.
  - The raster is free-running; frame-to-frame continuity has no gaps.
- Decode, from the counters, registered one cycle:
  - `de` = RUN && `hcnt`<H_ACTIVE && `vcnt`<V_ACTIVE
  - `hsync` low when H_ACTIVE+H_FP <= `hcnt` < H_ACTIVE+H_FP+H_SYNC
  - `vsync` low when V_ACTIVE+V_FP <= `vcnt` < V_ACTIVE+V_FP+V_SYNC; it changes only alongside `hcnt`=0
  - `x`=`hcnt`, `y`=`vcnt` when `de`=1; otherwise both hold 0
  - `frame_start` = RUN && `hcnt`=0 && `vcnt`=0
- Outside RUN, all outputs are held at their inactive values: `hsync`=`vsync`=1, `de`=0, `x`=`y`=0, `frame_start`=0.
- Loss of lock mid-line or mid-frame blanks the outputs immediately; no partial line is completed. Relock restarts the settle period and the raster begins from (0,0).

## Timing
- Reset values: `hsync`=1, `vsync`=1, `de`=0, `x`=0, `y`=0, `frame_start`=0, `running`=0; state WAIT_LOCK; all counters 0.
- `rst` overrides everything, including a simultaneous `locked` change.
- Startup latency, with edge E0 being the first edge that samples `locked`=1:
  - `locked_s`=1 after E1.
  - SETTLE entered at E2.
  - RUN entered at E(LOCK_WAIT+2).
  - First `frame_start`/`de` high after E(LOCK_WAIT+3).
  - `running` rises together with the first `frame_start`; it is registered with the other outputs.
- Lock loss, with edge F0 being the first edge that samples `locked`=0: outputs go inactive after F3.
- A `locked` low glitch shorter than 1 cycle may be missed. A glitch of 2 or more cycles is always caught.
- Fixed output latency: 1 cycle from counters to outputs. All outputs are mutually aligned.

## Configuration
- `VTG_LOCK_FILTER_EN` defined: SETTLE state and `settle_cnt` are present, and `LOCK_WAIT` applies as above.
- Not defined: WAIT_LOCK goes directly to RUN when `locked_s`=1. `LOCK_WAIT` is ignored. First `frame_start` appears after E3.

## Test plan
- Reset, then `locked`=0 for 5000 cycles -> outputs stay at reset values and `running`=0 throughout.
- `locked` rises at E0, filter enabled, LOCK_WAIT=1024 -> first `frame_start` after E1027. `de` stays high for exactly 800 cycles per line, and the line period is 976 cycles.
- Full frame -> `hsync` low for 48 cycles starting 840 cycles after `de` rises. `vsync` low for 3×976 cycles starting at line 493. The next `frame_start` comes 515328 cycles after the previous one.
- `locked` drops 10 cycles at line 100, pixel 400 -> outputs go inactive 3 cycles later. After relock, the next `frame_start` comes LOCK_WAIT+3 cycles after `locked` is re-sampled high.
- `locked` drops for 5 cycles during SETTLE (cycle 500) -> the settle count restarts, and `frame_start` comes LOCK_WAIT+3 cycles after the final rise.
- `rst` asserted mid-frame at pixel (300,200) with `locked`=1 -> all outputs at reset values on the next edge. The filter-disabled build restarts `frame_start` 4 cycles after `rst` is released.
